// File: rtl/fft_pkg.sv
// fft_pkg
//   Definitions shared by the forward and inverse radix-4 butterflies.
//   - HALF_WIDTH: width of one Q1.15 component.
//   - Q15_MAX / Q15_MIN: saturation limits for a Q1.15 component.
//   - TW_ONE: twiddle real part equal to 1.0 (Q2.15).
//   - cplx16_t: packed complex sample {re, im}, each signed Q1.15.
//   - twid17_t: packed twiddle {re, im}, each signed Q2.15.
//   - sat16(): clips a 19-bit value to Q1.15 and reports whether it clipped.
package fft_pkg;

  localparam int HALF_WIDTH = 16;
  localparam int TW_WIDTH   = HALF_WIDTH + 1;   // Q2.15 twiddle component
  localparam int PROD_WIDTH = HALF_WIDTH + TW_WIDTH;  // full-precision 16x17 product
  localparam int SUM_WIDTH  = PROD_WIDTH + 1;   // sum/difference of two products
  localparam int T_WIDTH    = 19;               // rotated term after >>>15
  localparam int ACC_WIDTH  = 21;               // a + three rotated terms

  localparam logic signed [HALF_WIDTH-1:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [HALF_WIDTH-1:0] Q15_MIN = 16'sh8000;
  localparam logic signed [TW_WIDTH-1:0]   TW_ONE  = 17'sh08000;

  typedef struct packed {
    logic signed [HALF_WIDTH-1:0] re;
    logic signed [HALF_WIDTH-1:0] im;
  } cplx16_t;

  typedef struct packed {
    logic signed [TW_WIDTH-1:0] re;
    logic signed [TW_WIDTH-1:0] im;
  } twid17_t;

  typedef struct packed {
    logic                         sat;
    logic signed [HALF_WIDTH-1:0] val;
  } sat16_t;

  function automatic sat16_t sat16(input logic signed [T_WIDTH-1:0] x);
    sat16_t r;
    r.sat = 1'b0;
    r.val = x[HALF_WIDTH-1:0];
    if (x > T_WIDTH'(Q15_MAX)) begin
      r.sat = 1'b1;
      r.val = Q15_MAX;
    end else if (x < T_WIDTH'(Q15_MIN)) begin
      r.sat = 1'b1;
      r.val = Q15_MIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmul_q15.sv
// cmul_q15
//   Registered partial products of x * conj(w) for one radix-4 leg.
//   The four products are kept at full precision; the caller forms
//     re = p_rr + p_ii,  im = p_ir - p_ri.
// Ports
//   clk     in   sole clock, rising edge
//   i_en    in   capture new products this cycle
//   i_x     in   complex sample, Q1.15 components
//   i_w     in   twiddle, Q2.15 components
//   o_p_rr  out  x.re * w.re
//   o_p_ii  out  x.im * w.im
//   o_p_ir  out  x.im * w.re
//   o_p_ri  out  x.re * w.im
module cmul_q15
  import fft_pkg::*;
(
  input  logic                         clk,
  input  logic                         i_en,
  input  cplx16_t                      i_x,
  input  twid17_t                      i_w,
  output logic signed [PROD_WIDTH-1:0] o_p_rr,
  output logic signed [PROD_WIDTH-1:0] o_p_ii,
  output logic signed [PROD_WIDTH-1:0] o_p_ir,
  output logic signed [PROD_WIDTH-1:0] o_p_ri
);

  logic signed [PROD_WIDTH-1:0] r_p_rr;
  logic signed [PROD_WIDTH-1:0] r_p_ii;
  logic signed [PROD_WIDTH-1:0] r_p_ir;
  logic signed [PROD_WIDTH-1:0] r_p_ri;

  logic signed [PROD_WIDTH-1:0] w_xr;
  logic signed [PROD_WIDTH-1:0] w_xi;
  logic signed [PROD_WIDTH-1:0] w_wr;
  logic signed [PROD_WIDTH-1:0] w_wi;

  // Sign-extend operands to the product width so the multiply is exact.
  assign w_xr = PROD_WIDTH'(i_x.re);
  assign w_xi = PROD_WIDTH'(i_x.im);
  assign w_wr = PROD_WIDTH'(i_w.re);
  assign w_wi = PROD_WIDTH'(i_w.im);

  // Data-only register: validity is tracked by the parent pipeline.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_p_rr <= w_xr * w_wr;
      r_p_ii <= w_xi * w_wi;
      r_p_ir <= w_xi * w_wr;
      r_p_ri <= w_xr * w_wi;
    end
  end

  assign o_p_rr = r_p_rr;
  assign o_p_ii = r_p_ii;
  assign o_p_ir = r_p_ir;
  assign o_p_ri = r_p_ri;

endmodule

// File: rtl/butterfly_4_inv_pipe.sv
// butterfly_4_inv_pipe
//   Pipelined radix-4 DIT inverse butterfly with 1/4 output scaling.
//   t_k = x_k * conj(w_k) for x = b, c, d, then
//     o0 = a + t1 + t2 + t3      o1 = a + j*t1 - t2 - j*t3
//     o2 = a - t1 + t2 - t3      o3 = a - j*t1 - t2 + j*t3
//   each floored >>>2 and saturated to Q1.15.
//   Stages: S1 partial products, S2 rotated terms, S3 scaled outputs.
//   Packing assumes WIDTH = 2*HALF_WIDTH.
// Ports
//   clk, rst            clock / synchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready is combinational)
//   a, b, c, d          input samples {re, im}
//   w1, w2, w3          twiddles {re, im}, Q2.15 components
//   out_valid, out_ready output handshake
//   out0..out3          output samples {re, im}
//   out_sat             bit k: outk clipped on either component
//   sat_clr             clears sat_sticky
//   sat_sticky          saturation seen on a transfer since reset/clear
module butterfly_4_inv_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH+1:0] w1,
  input  logic [WIDTH+1:0] w2,
  input  logic [WIDTH+1:0] w3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_sat,
  input  logic             sat_clr,
  output logic             sat_sticky
);

  genvar gi;

  // ---------------- pipeline control ----------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic r_s3_valid;
  logic w_load1;
  logic w_load2;
  logic w_load3;
  logic w_accept;

  // A stage may load when it is empty or its content moves on this cycle.
  assign w_load3  = !r_s3_valid || out_ready;
  assign w_load2  = !r_s2_valid || w_load3;
  assign w_load1  = !r_s1_valid || w_load2;
  assign in_ready = !rst && w_load1;
  assign w_accept = in_valid && in_ready;

  // ---------------- S1: products ----------------
  cplx16_t                      w_x   [3];
  twid17_t                      w_w   [3];
  logic signed [PROD_WIDTH-1:0] w_p_rr[3];
  logic signed [PROD_WIDTH-1:0] w_p_ii[3];
  logic signed [PROD_WIDTH-1:0] w_p_ir[3];
  logic signed [PROD_WIDTH-1:0] w_p_ri[3];
  logic signed [T_WIDTH-1:0]    w_t_re[3];
  logic signed [T_WIDTH-1:0]    w_t_im[3];
  cplx16_t                      r_s1_a;

  assign w_x[0] = b;
  assign w_x[1] = c;
  assign w_x[2] = d;
  assign w_w[0] = w1;
  assign w_w[1] = w2;
  assign w_w[2] = w3;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_leg
      logic signed [SUM_WIDTH-1:0] w_sum_re;
      logic signed [SUM_WIDTH-1:0] w_dif_im;

      cmul_q15 u_cmul (
        .clk    (clk),
        .i_en   (w_accept),
        .i_x    (w_x[gi]),
        .i_w    (w_w[gi]),
        .o_p_rr (w_p_rr[gi]),
        .o_p_ii (w_p_ii[gi]),
        .o_p_ir (w_p_ir[gi]),
        .o_p_ri (w_p_ri[gi])
      );

      // x * conj(w): re = xr*wr + xi*wi, im = xi*wr - xr*wi.
      assign w_sum_re = SUM_WIDTH'(w_p_rr[gi]) + SUM_WIDTH'(w_p_ii[gi]);
      assign w_dif_im = SUM_WIDTH'(w_p_ir[gi]) - SUM_WIDTH'(w_p_ri[gi]);
      // Back to Q.15 by floor shift; upper bits simply truncated.
      assign w_t_re[gi] = T_WIDTH'(w_sum_re >>> 15);
      assign w_t_im[gi] = T_WIDTH'(w_dif_im >>> 15);
    end
  endgenerate

  // ---------------- S2: rotated terms ----------------
  cplx16_t                   r_s2_a;
  logic signed [T_WIDTH-1:0] r_s2_t_re[3];
  logic signed [T_WIDTH-1:0] r_s2_t_im[3];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_a <= a;
    end
    if (w_load2 && r_s1_valid) begin
      r_s2_a    <= r_s1_a;
      r_s2_t_re <= w_t_re;
      r_s2_t_im <= w_t_im;
    end
  end

  // ---------------- S3 combine, scale, saturate ----------------
  logic signed [ACC_WIDTH-1:0] w_ar;
  logic signed [ACC_WIDTH-1:0] w_ai;
  logic signed [ACC_WIDTH-1:0] w_tr[3];
  logic signed [ACC_WIDTH-1:0] w_ti[3];
  logic signed [ACC_WIDTH-1:0] w_sum_re[4];
  logic signed [ACC_WIDTH-1:0] w_sum_im[4];
  logic [WIDTH-1:0]            w_out[4];
  logic [3:0]                  w_out_sat;

  assign w_ar = ACC_WIDTH'(r_s2_a.re);
  assign w_ai = ACC_WIDTH'(r_s2_a.im);

  generate
    for (gi = 0; gi < 3; gi++) begin : g_ext
      assign w_tr[gi] = ACC_WIDTH'(r_s2_t_re[gi]);
      assign w_ti[gi] = ACC_WIDTH'(r_s2_t_im[gi]);
    end
  endgenerate

  // j*t = (-t.im, t.re); -j*t = (t.im, -t.re).
  assign w_sum_re[0] = w_ar + w_tr[0] + w_tr[1] + w_tr[2];
  assign w_sum_im[0] = w_ai + w_ti[0] + w_ti[1] + w_ti[2];
  assign w_sum_re[1] = w_ar - w_ti[0] - w_tr[1] + w_ti[2];
  assign w_sum_im[1] = w_ai + w_tr[0] - w_ti[1] - w_tr[2];
  assign w_sum_re[2] = w_ar - w_tr[0] + w_tr[1] - w_tr[2];
  assign w_sum_im[2] = w_ai - w_ti[0] + w_ti[1] - w_ti[2];
  assign w_sum_re[3] = w_ar + w_ti[0] - w_tr[1] - w_ti[2];
  assign w_sum_im[3] = w_ai - w_tr[0] - w_ti[1] + w_tr[2];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      sat16_t w_sat_re;
      sat16_t w_sat_im;
      // 1/4 scaling is a floor shift before clipping.
      assign w_sat_re      = sat16(T_WIDTH'(w_sum_re[gi] >>> 2));
      assign w_sat_im      = sat16(T_WIDTH'(w_sum_im[gi] >>> 2));
      assign w_out[gi]     = {w_sat_re.val, w_sat_im.val};
      assign w_out_sat[gi] = w_sat_re.sat | w_sat_im.sat;
    end
  endgenerate

  logic [WIDTH-1:0] r_out[4];
  logic [3:0]       r_out_sat;
  logic             r_sat_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s3_valid   <= 1'b0;
      r_out_sat    <= '0;
      r_sat_sticky <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_out[k] <= '0;
      end
    end else begin
      if (w_load1) begin
        r_s1_valid <= in_valid;
      end
      if (w_load2) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_load3) begin
        r_s3_valid <= r_s2_valid;
        // Only overwrite the output registers with real data.
        if (r_s2_valid) begin
          r_out     <= w_out;
          r_out_sat <= w_out_sat;
        end
      end
      // A saturating transfer in the same cycle as sat_clr keeps the flag set.
      if (r_s3_valid && out_ready && (|r_out_sat)) begin
        r_sat_sticky <= 1'b1;
      end else if (sat_clr) begin
        r_sat_sticky <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s3_valid;
  assign out0       = r_out[0];
  assign out1       = r_out[1];
  assign out2       = r_out[2];
  assign out3       = r_out[3];
  assign out_sat    = r_out_sat;
  assign sat_sticky = r_sat_sticky;

endmodule
